// File: rtl/branch_predict_unit.sv
// Purpose: EXE branch resolution, mispredict recovery, direct-mapped BTB with 2-bit counters, branch/mispredict stats.
// Latency: lookup and resolve outputs are combinational; BTB and statistics updates are visible the cycle after the resolve edge.
// Backpressure: none; a resolve can be accepted every cycle and the IF lookup is always available.
module branch_predict_unit #(
    parameter int PC_W   = 16,
    parameter int IDX_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic [1:0]        ex_type,
    input  logic              equal,
    input  logic              zero,
    input  logic              less,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [PC_W-1:0]   ex_target,
    input  logic [PC_W-1:0]   ex_fall_pc,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    output logic              pcsrc,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush,
    input  logic              clear_stats,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mis_count
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = PC_W - IDX_W;

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [1:0]       cnt;
        logic [PC_W-1:0]  target;
    } btb_entry_t;

    btb_entry_t btb [DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    btb_entry_t       if_entry;
    btb_entry_t       ex_entry;
    logic             if_hit;
    logic             ex_hit;
    logic             le_cond;
    logic             actual_taken;
    logic             resolve;
    logic             mispredict;

    assign if_idx   = if_pc[IDX_W-1:0];
    assign if_tag   = if_pc[PC_W-1:IDX_W];
    assign ex_idx   = ex_pc[IDX_W-1:0];
    assign ex_tag   = ex_pc[PC_W-1:IDX_W];
    assign if_entry = btb[if_idx];
    assign ex_entry = btb[ex_idx];
    assign if_hit   = if_entry.vld && (if_entry.tag == if_tag);
    assign ex_hit   = ex_entry.vld && (ex_entry.tag == ex_tag);

    // Fetch-side prediction reads the stored entry only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_taken  = if_hit & if_entry.cnt[1];
        pred_target = if_hit ? if_entry.target : '0;
    end

    // Branch condition from the ALU flags, selected by branch type.
    always_comb begin
        le_cond = zero | less;
        case (ex_type)
            2'b01:   actual_taken = equal;
            2'b10:   actual_taken = ~le_cond;
            2'b11:   actual_taken = le_cond;
            default: actual_taken = 1'b0;
        endcase
    end

    // Mispredict on wrong direction, or on a taken branch whose carried target is stale.
    always_comb begin
        resolve     = ex_valid && (ex_type != 2'b00);
        mispredict  = resolve && ((actual_taken != ex_pred_taken) ||
                                  (actual_taken && (ex_pred_target != ex_target)));
        pcsrc       = mispredict;
        flush       = mispredict;
        redirect_pc = actual_taken ? ex_target : ex_fall_pc;
    end

    // BTB training: saturating counter on hit, allocate only on a taken miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                btb[i].vld    <= 1'b0;
                btb[i].tag    <= '0;
                btb[i].cnt    <= 2'b01;
                btb[i].target <= '0;
            end
        end else if (resolve) begin
            if (ex_hit) begin
                if (actual_taken) begin
                    if (ex_entry.cnt != 2'b11) begin
                        btb[ex_idx].cnt <= ex_entry.cnt + 2'b01;
                    end
                    btb[ex_idx].target <= ex_target;
                end else if (ex_entry.cnt != 2'b00) begin
                    btb[ex_idx].cnt <= ex_entry.cnt - 2'b01;
                end
            end else if (actual_taken) begin
                btb[ex_idx].vld    <= 1'b1;
                btb[ex_idx].tag    <= ex_tag;
                btb[ex_idx].cnt    <= 2'b10;
                btb[ex_idx].target <= ex_target;
            end
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (clear_stats) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (resolve && (br_count != '1)) begin
                br_count <= br_count + 1'b1;
            end
            if (mispredict && (mis_count != '1)) begin
                mis_count <= mis_count + 1'b1;
            end
        end
    end

endmodule
